picomips_fetch: RTL and testbench
=================================

// Module: picomips_fetch
// PURPOSE
//  Instruction-fetch / sequencer stage: the producing end of the decoder's 24-bit instruction bus.
//  Holds the PC and addresses the async-read program ROM. Registers the fetched word onto bus.
//  Redirects the PC on branches and stalls on switch-wait instructions until a debounced SW8 reaches the requested level.
//  Sits between program ROM and decoder; the decoder's branch/wait flags feed back into this block.
// PARAMETERS
//  PC_WIDTH         6   program address width; ROM depth 2**PC_WIDTH
//  BUS_WIDTH        24  instruction width = INST_WIDTH+2*ADDR_WIDTH+DATA_WIDTH
//  DEBOUNCE_CYCLES  4   consecutive stable synced cycles before sw_clean changes (>=1)
// PORTS
//  clk            in   1          system clock, rising edge
//  reset          in   1          asynchronous, active-high
//  SW8            in   1          raw async switch input
//  prog_addr      out  PC_WIDTH   ROM read address (= pc register, combinational)
//  prog_data      in   BUS_WIDTH  ROM word at prog_addr, same cycle
//  bus            out  BUS_WIDTH  registered instruction presented to decoder
//  cur_pc         out  PC_WIDTH   address of instruction currently on bus
//  branch_take    in   1          decoder: instruction on bus is a taken branch
//  branch_rel     in   1          1 = target cur_pc+branch_off; 0 = absolute branch_off
//  branch_off     in   PC_WIDTH   branch offset (two's complement) / absolute target
//  wait_req       in   1          decoder: instruction on bus waits on switch
//  wait_level     in   1          level of sw_clean that releases the wait
//  stall          out  1          1 while in WAIT_SW
//  sw_clean       out  1          synchronised, debounced SW8
// BEHAVIOUR
//  Reset (async): pc=0, cur_pc=0, bus=0 (NOP), stall=0, sw_clean=0, sync flops=0, debounce cnt=0, state=FILL.
//  FILL (1 cycle): bus<=prog_data, cur_pc<=pc, pc<=pc+1 -> RUN.
//  RUN, evaluated each cycle in priority order:
//   1. wait_req && sw_clean!=wait_level: hold pc, bus, cur_pc; ->WAIT_SW; stall=1 from next cycle.
//   2. branch_take: pc<=target; bus<=0 (flush bubble); cur_pc unchanged -> FILL.
//      Net: the target instruction appears on bus 2 cycles after the branch was on bus.
//   3. else: bus<=prog_data, cur_pc<=pc, pc<=pc+1 (one instruction per cycle).
//  wait_req with level already met: no stall, falls through to 2/3.
//  WAIT_SW: everything held; when sw_clean==wait_level -> RUN, stall<=0.
//   The bus still holds the wait instruction, so RUN re-evaluates it.
//   A wait+branch instruction therefore branches only after release.
//  Target arithmetic: rel = cur_pc+branch_off mod 2**PC_WIDTH; pc+1 wraps max->0.
//  A bubble (bus=0) must decode as NOP with no branch/wait flags. branch_* and wait_* are ignored in FILL.
//  SW8: 2-flop synchroniser -> sw_sync.
//   Counter increments while sw_sync!=sw_clean; clears when they are equal.
//   At DEBOUNCE_CYCLES: sw_clean<=sw_sync, cnt<=0.
//   Total latency raw->sw_clean = 2+DEBOUNCE_CYCLES cycles; glitches shorter than DEBOUNCE_CYCLES are rejected.
//  Reset mid-wait or mid-branch: immediate return to reset values; fetch restarts at address 0.
// TESTING
//  T1 reset release, ROM[0..3]=A,B,C,D, no flags -> bus=A,B,C,D on consecutive cycles after the FILL cycle; cur_pc=0,1,2,3.
//  T2 branch_take abs, off=0x10 while cur_pc=2 -> one bus=0 cycle, then FILL, then bus=ROM[0x10], cur_pc=0x10.
//  T3 branch_rel, cur_pc=0x3E, off=0x05 -> target 0x03 (wrap); off=0x3F (-1) from 0x05 -> 0x04.
//  T4 wait_req, wait_level=1, SW8=0 -> stall=1, bus held 10 cycles.
//     SW8 raised -> stall drops 2+4+1 cycles later; next instruction follows.
//  T5 SW8 glitch high 3 cycles during wait -> sw_clean stays 0, stall stays 1.
//     Wait+branch released -> branch taken after release.
//  T6 reset asserted during WAIT_SW -> bus=0, stall=0, sw_clean=0 immediately; after release, ROM[0] fetched.
//     PC wraps 0x3F->0x00 in a linear run.

Source files
------------

// File: rtl/picomips_fetch_if.sv
// rtl/picomips_fetch_if.sv - fetch-stage bus bundle between fetch, program ROM and decoder
//
// Purpose: groups the program-ROM read port and the decoder-facing instruction bus
//          together with the decoder's branch/wait feedback.
// Signals:
//   prog_addr   ROM read address (driven by fetch)
//   prog_data   ROM word at prog_addr, same cycle (driven by ROM)
//   bus         registered instruction presented to decoder
//   cur_pc      address of the instruction currently on bus
//   branch_take decoder: instruction on bus is a taken branch
//   branch_rel  1 = relative target cur_pc+branch_off, 0 = absolute branch_off
//   branch_off  two's complement offset or absolute target
//   wait_req    decoder: instruction on bus waits on the switch
//   wait_level  sw_clean level that releases the wait
//   stall       fetch is parked waiting for the switch
// Modports: master = fetch stage, slave = ROM/decoder side.

interface picomips_fetch_if #(
  parameter int PC_WIDTH  = 6,
  parameter int BUS_WIDTH = 24
);
  logic [PC_WIDTH-1:0]  prog_addr;
  logic [BUS_WIDTH-1:0] prog_data;
  logic [BUS_WIDTH-1:0] bus;
  logic [PC_WIDTH-1:0]  cur_pc;
  logic                 branch_take;
  logic                 branch_rel;
  logic [PC_WIDTH-1:0]  branch_off;
  logic                 wait_req;
  logic                 wait_level;
  logic                 stall;

  modport master (
    output prog_addr, bus, cur_pc, stall,
    input  prog_data, branch_take, branch_rel, branch_off, wait_req, wait_level
  );

  modport slave (
    input  prog_addr, bus, cur_pc, stall,
    output prog_data, branch_take, branch_rel, branch_off, wait_req, wait_level
  );
endinterface

// File: rtl/picomips_fetch.sv
// rtl/picomips_fetch.sv - instruction fetch / sequencer stage with switch-wait stall
//
// Purpose: holds the PC, addresses the async-read program ROM and registers the
//          fetched word onto the decoder bus. Redirects on taken branches (one
//          bubble plus a refill cycle) and stalls on switch-wait instructions until
//          the synchronised, debounced SW8 reaches the requested level.
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high
//   SW8       raw asynchronous switch input
//   sw_clean  synchronised, debounced SW8
//   fi        fetch bundle (master): ROM port, bus/cur_pc/stall out, decoder flags in

module picomips_fetch #(
  parameter int PC_WIDTH        = 6,
  parameter int BUS_WIDTH       = 24,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SW8,
  output logic             sw_clean,
  picomips_fetch_if.master fi
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1; the terminal cycle updates sw_clean.
  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_RUN     = 2'd1,
    ST_WAIT_SW = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [PC_WIDTH-1:0]  cur_pc_q, cur_pc_d;
  logic [BUS_WIDTH-1:0] bus_q, bus_d;
  logic                 stall_q, stall_d;

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 sw_clean_q, sw_clean_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [PC_WIDTH-1:0]  pc_inc;
  logic [PC_WIDTH-1:0]  branch_target;

  // ---------------------------------------------------------------------------
  // Switch synchroniser and debouncer
  // ---------------------------------------------------------------------------
  always_comb begin
    sync1_d    = SW8;
    sync2_d    = sync1_q;
    sw_clean_d = sw_clean_q;
    cnt_d      = '0;
    // Any cycle where the synced value agrees with sw_clean restarts the count,
    // so only runs of DEBOUNCE_CYCLES consecutive disagreeing cycles get through.
    if (sync2_q != sw_clean_q) begin
      if (cnt_q == CNT_LAST) begin
        sw_clean_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch sequencer
  // ---------------------------------------------------------------------------
  assign pc_inc        = pc_q + PC_WIDTH'(1);
  // Relative targets wrap modulo the program space, like the PC itself.
  assign branch_target = fi.branch_rel ? (cur_pc_q + fi.branch_off) : fi.branch_off;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cur_pc_d = cur_pc_q;
    bus_d    = bus_q;
    stall_d  = stall_q;

    case (state_q)
      // Decoder flags are ignored here: the bus holds a bubble or the reset NOP.
      ST_FILL: begin
        bus_d    = fi.prog_data;
        cur_pc_d = pc_q;
        pc_d     = pc_inc;
        state_d  = ST_RUN;
      end

      ST_RUN: begin
        if (fi.wait_req && (sw_clean_q != fi.wait_level)) begin
          // Park with the wait instruction still on the bus.
          state_d = ST_WAIT_SW;
          stall_d = 1'b1;
        end else if (fi.branch_take) begin
          // Flush: the fall-through word already addressed is discarded and a
          // NOP bubble goes to the decoder while FILL reads the target.
          pc_d    = branch_target;
          bus_d   = '0;
          state_d = ST_FILL;
        end else begin
          bus_d    = fi.prog_data;
          cur_pc_d = pc_q;
          pc_d     = pc_inc;
        end
      end

      ST_WAIT_SW: begin
        // Return to RUN without fetching so a combined wait+branch instruction
        // is re-evaluated and takes its branch only after release.
        if (sw_clean_q == fi.wait_level) begin
          state_d = ST_RUN;
          stall_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_FILL;
        stall_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FILL;
      pc_q       <= '0;
      cur_pc_q   <= '0;
      bus_q      <= '0;
      stall_q    <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sw_clean_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cur_pc_q   <= cur_pc_d;
      bus_q      <= bus_d;
      stall_q    <= stall_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sw_clean_q <= sw_clean_d;
      cnt_q      <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign fi.prog_addr = pc_q;
  assign fi.bus       = bus_q;
  assign fi.cur_pc    = cur_pc_q;
  assign fi.stall     = stall_q;
  assign sw_clean     = sw_clean_q;

endmodule

// File: tb/tb_picomips_fetch.sv
// tb/tb_picomips_fetch.sv - directed self-checking bench for picomips_fetch

module tb_picomips_fetch;

  logic clk;
  logic reset;
  logic sw8;
  logic sw_clean;

  logic [23:0] rom [64];

  int n_assert = 0;
  int n_fail   = 0;
  int clean_k;
  int stall_k;

  picomips_fetch_if #(.PC_WIDTH(6), .BUS_WIDTH(24)) fi ();

  picomips_fetch #(
    .PC_WIDTH(6),
    .BUS_WIDTH(24),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .SW8      (sw8),
    .sw_clean (sw_clean),
    .fi       (fi)
  );

  // Program ROM and a minimal decoder: word[23]=branch, [22]=rel, [21]=wait,
  // [20]=wait level, [5:0]=offset/target. A zero word carries no flags.
  assign fi.prog_data   = rom[fi.prog_addr];
  assign fi.branch_take = fi.bus[23];
  assign fi.branch_rel  = fi.bus[22];
  assign fi.wait_req    = fi.bus[21];
  assign fi.wait_level  = fi.bus[20];
  assign fi.branch_off  = fi.bus[5:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] plain(input int i);
    return 24'h010000 | (24'(i) << 8);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic load_plain();
    for (int i = 0; i < 64; i++) rom[i] = plain(i);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sw8   = 1'b0;
    load_plain();

    // T1: reset values, then linear fetch A,B,C,D
    cyc();
    cyc();
    chk("rst_bus", fi.bus, 24'h0);
    chk("rst_cur_pc", fi.cur_pc, 6'h0);
    chk("rst_prog_addr", fi.prog_addr, 6'h0);
    chk("rst_stall", fi.stall, 1'b0);
    chk("rst_sw_clean", sw_clean, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t1_bus", fi.bus, plain(i));
      chk("t1_cur_pc", fi.cur_pc, 32'(i));
    end

    // T2: absolute branch to 0x10 from address 2
    load_plain();
    rom[2] = 24'h800010;
    cyc();
    pulse_reset();
    cyc(); cyc(); cyc();
    chk("t2_br_bus", fi.bus, 24'h800010);
    chk("t2_br_cur", fi.cur_pc, 6'h02);
    cyc();
    chk("t2_bubble", fi.bus, 24'h0);
    chk("t2_bubble_cur", fi.cur_pc, 6'h02);
    chk("t2_bubble_addr", fi.prog_addr, 6'h10);
    cyc();
    chk("t2_tgt_bus", fi.bus, plain(16));
    chk("t2_tgt_cur", fi.cur_pc, 6'h10);
    cyc();
    chk("t2_next_cur", fi.cur_pc, 6'h11);

    // T3: relative branches with wrap (0x3E+5 -> 0x03, 0x05-1 -> 0x04)
    load_plain();
    rom[0]     = 24'h80003E;
    rom[6'h3E] = 24'hC00005;
    rom[5]     = 24'hC0003F;
    pulse_reset();
    cyc();
    chk("t3_abs_bus", fi.bus, 24'h80003E);
    cyc();
    chk("t3_abs_addr", fi.prog_addr, 6'h3E);
    cyc();
    chk("t3_rel_cur", fi.cur_pc, 6'h3E);
    cyc();
    chk("t3_wrap_addr", fi.prog_addr, 6'h03);
    cyc();
    chk("t3_wrap_bus", fi.bus, plain(3));
    chk("t3_wrap_cur", fi.cur_pc, 6'h03);
    cyc(); cyc();
    chk("t3_neg_bus", fi.bus, 24'hC0003F);
    cyc();
    chk("t3_neg_addr", fi.prog_addr, 6'h04);
    cyc();
    chk("t3_neg_cur", fi.cur_pc, 6'h04);

    // T4: wait for level 1 with SW8 low, then release
    load_plain();
    rom[1] = 24'h300000;
    pulse_reset();
    cyc(); cyc();
    chk("t4_wait_bus", fi.bus, 24'h300000);
    chk("t4_no_stall_yet", fi.stall, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t4_stall", fi.stall, 1'b1);
      chk("t4_hold_bus", fi.bus, 24'h300000);
    end
    chk("t4_hold_cur", fi.cur_pc, 6'h01);
    sw8 = 1'b1;
    clean_k = 0;
    stall_k = 0;
    for (int k = 1; k <= 20 && stall_k == 0; k++) begin
      cyc();
      if (clean_k == 0 && sw_clean) clean_k = k;
      if (!fi.stall) stall_k = k;
    end
    chk("t4_clean_lat", clean_k, 6);
    chk("t4_stall_lat", stall_k, 7);
    chk("t4_release_bus", fi.bus, 24'h300000);
    cyc();
    chk("t4_next_bus", fi.bus, plain(2));
    chk("t4_next_cur", fi.cur_pc, 6'h02);

    // T5: 3-cycle glitch rejected, then wait+branch to 0x20 after release
    sw8 = 1'b0;
    load_plain();
    rom[1] = 24'hB00020;
    pulse_reset();
    cyc(); cyc(); cyc();
    chk("t5_stall", fi.stall, 1'b1);
    sw8 = 1'b1;
    cyc(); cyc(); cyc();
    sw8 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t5_glitch_stall_clean", {fi.stall, sw_clean}, 2'b10);
    end
    sw8 = 1'b1;
    stall_k = 0;
    for (int k = 1; k <= 20 && stall_k == 0; k++) begin
      cyc();
      if (!fi.stall) stall_k = k;
    end
    chk("t5_stall_lat", stall_k, 7);
    chk("t5_release_bus", fi.bus, 24'hB00020);
    cyc();
    chk("t5_bubble", fi.bus, 24'h0);
    chk("t5_bubble_addr", fi.prog_addr, 6'h20);
    cyc();
    chk("t5_tgt_bus", fi.bus, plain(32));
    chk("t5_tgt_cur", fi.cur_pc, 6'h20);

    // T6: reset mid-wait, then restart at 0 and PC wrap in a linear run
    sw8 = 1'b0;
    load_plain();
    rom[1] = 24'h300000;
    pulse_reset();
    cyc(); cyc(); cyc();
    sw8 = 1'b1;
    repeat (6) cyc();
    chk("t6_pre_clean", sw_clean, 1'b1);
    chk("t6_pre_stall", fi.stall, 1'b1);
    reset = 1'b1;
    #1;
    chk("t6_async_bus", fi.bus, 24'h0);
    chk("t6_async_stall", fi.stall, 1'b0);
    chk("t6_async_clean", sw_clean, 1'b0);
    chk("t6_async_addr", fi.prog_addr, 6'h0);
    sw8 = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    chk("t6_restart_bus", fi.bus, plain(0));
    chk("t6_restart_cur", fi.cur_pc, 6'h0);

    rom[1] = plain(1);
    pulse_reset();
    for (int k = 1; k <= 65; k++) begin
      cyc();
      if (k == 64) begin
        chk("t6_last_cur", fi.cur_pc, 6'h3F);
        chk("t6_wrap_addr", fi.prog_addr, 6'h00);
      end
      if (k == 65) begin
        chk("t6_wrap_cur", fi.cur_pc, 6'h00);
        chk("t6_wrap_bus", fi.bus, plain(0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
